// File: rtl/npu_host_seq.sv
// Host-side NPU run sequencer: instruction load, lockstep input push,
// start pulse, then lockstep drain with a cross-port consistency check.
module npu_host_seq #(
    parameter int EW         = 8,
    parameter int DOTW       = 40,
    parameter int MICW       = 64,
    parameter int INST_ADDRW = 9,
    parameter int CNTW       = 16,
    parameter int CYCW       = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [INST_ADDRW:0]   i_num_inst,
    input  logic [CNTW-1:0]       i_num_inputs,
    input  logic [CNTW-1:0]       i_num_outputs,
    input  logic [31:0]           i_pc_offset,

    input  logic                  i_inst_valid,
    output logic                  o_inst_ready,
    input  logic [MICW-1:0]       i_inst_data,
    output logic                  o_inst_wr_en,
    output logic [INST_ADDRW-1:0] o_inst_wr_addr,
    output logic [MICW-1:0]       o_inst_wr_data,

    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [EW*DOTW-1:0]    i_in_data,
    output logic                  o_ld_in_wr_en,
    output logic [EW*DOTW-1:0]    o_ld_in_wr_din,
    input  logic                  i_ld_in_wr_rdy0,
    input  logic                  i_ld_in_wr_rdy1,

    output logic                  o_start,
    output logic [31:0]           o_pc_start_offset,

    input  logic                  i_ld_out_rd_rdy0,
    input  logic                  i_ld_out_rd_rdy1,
    input  logic [EW*DOTW-1:0]    i_ld_out_rd_dout0,
    input  logic [EW*DOTW-1:0]    i_ld_out_rd_dout1,
    output logic                  o_ld_out_rd_en,

    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [EW*DOTW-1:0]    o_out_data,

    output logic                  o_mismatch,
    output logic [CYCW-1:0]       o_cycles,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int VW = EW * DOTW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INST,
        S_INPUT,
        S_START,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [INST_ADDRW:0]   num_inst_q;
    logic [CNTW-1:0]       num_in_q;
    logic [CNTW-1:0]       num_out_q;
    logic [INST_ADDRW-1:0] inst_addr;
    logic [CNTW-1:0]       in_cnt;
    logic [CNTW-1:0]       out_cnt;
    logic [31:0]           pc_q;
    logic [CYCW-1:0]       cycles_q;
    logic                  mismatch_q;
    logic                  out_valid_q;
    logic [VW-1:0]         out_data_q;

    logic cmd_ready;
    logic inst_ready;
    logic in_ready;
    logic rd_en;
    logic start;
    logic done;

    logic accept;
    logic inst_wr;
    logic in_wr;
    logic inst_zero;
    logic in_zero;
    logic out_zero;
    logic inst_last;
    logic in_last;
    logic out_last;
    logic both_in_rdy;
    logic both_out_rdy;
    logic counting;

    assign inst_zero    = (num_inst_q == '0);
    assign in_zero      = (num_in_q == '0);
    assign out_zero     = (num_out_q == '0);
    assign inst_last    = ({1'b0, inst_addr} == num_inst_q - 1'b1);
    assign in_last      = (in_cnt == num_in_q - 1'b1);
    assign out_last     = (out_cnt == num_out_q - 1'b1);
    assign both_in_rdy  = i_ld_in_wr_rdy0 & i_ld_in_wr_rdy1;
    assign both_out_rdy = i_ld_out_rd_rdy0 & i_ld_out_rd_rdy1;
    assign counting     = (state == S_START) || (state == S_DRAIN);

    assign accept  = cmd_ready & i_cmd_valid;
    assign inst_wr = inst_ready & i_inst_valid;
    assign in_wr   = in_ready & i_in_valid;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; zero-count phases still occupy one cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_INST;
            end
            S_INST: begin
                if (inst_zero || (inst_wr && inst_last))
                    state_nxt = S_INPUT;
            end
            S_INPUT: begin
                if (in_zero || (in_wr && in_last))
                    state_nxt = S_START;
            end
            S_START: begin
                state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_zero || (rd_en && out_last))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!out_valid_q) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready  = 1'b0;
        inst_ready = 1'b0;
        in_ready   = 1'b0;
        rd_en      = 1'b0;
        start      = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_INST: begin
                inst_ready = !inst_zero;
            end
            S_INPUT: begin
                in_ready = !in_zero && both_in_rdy;
            end
            S_START: begin
                start = 1'b1;
            end
            S_DRAIN: begin
                rd_en = !out_zero && both_out_rdy
                        && (!out_valid_q || i_out_ready);
            end
            S_DONE: begin
                done = !out_valid_q;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Command latch and phase counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_inst_q <= '0;
            num_in_q   <= '0;
            num_out_q  <= '0;
            pc_q       <= '0;
            inst_addr  <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
        end else if (accept) begin
            num_inst_q <= i_num_inst;
            num_in_q   <= i_num_inputs;
            num_out_q  <= i_num_outputs;
            pc_q       <= i_pc_offset;
            inst_addr  <= '0;
            in_cnt     <= '0;
            out_cnt    <= '0;
        end else begin
            if (inst_wr) inst_addr <= inst_addr + 1'b1;
            if (in_wr)   in_cnt    <= in_cnt + 1'b1;
            if (rd_en)   out_cnt   <= out_cnt + 1'b1;
        end
    end

    // Run statistics held until the next accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycles_q   <= '0;
            mismatch_q <= 1'b0;
        end else if (accept) begin
            cycles_q   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (counting && !(&cycles_q))
                cycles_q <= cycles_q + 1'b1;
            if (rd_en && (i_ld_out_rd_dout0 != i_ld_out_rd_dout1))
                mismatch_q <= 1'b1;
        end
    end

    // Result register; a same-cycle read reloads instead of clearing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (rd_en) begin
            out_valid_q <= 1'b1;
            out_data_q  <= i_ld_out_rd_dout0;
        end else if (i_out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign o_cmd_ready       = cmd_ready;
    assign o_inst_ready      = inst_ready;
    assign o_inst_wr_en      = inst_wr;
    assign o_inst_wr_addr    = inst_addr;
    assign o_inst_wr_data    = i_inst_data;
    assign o_in_ready        = in_ready;
    assign o_ld_in_wr_en     = in_wr;
    assign o_ld_in_wr_din    = i_in_data;
    assign o_start           = start;
    assign o_pc_start_offset = pc_q;
    assign o_ld_out_rd_en    = rd_en;
    assign o_out_valid       = out_valid_q;
    assign o_out_data        = out_data_q;
    assign o_mismatch        = mismatch_q;
    assign o_cycles          = cycles_q;
    assign o_busy            = (state != S_IDLE);
    assign o_done            = done;

endmodule

// File: tb/tb_npu_host_seq.sv
// Randomized bench for npu_host_seq against a transaction-level model
// of the run: ordered phases, scoreboards and timing formulas.
module tb_npu_host_seq;

    localparam int EW   = 8;
    localparam int DOTW = 40;
    localparam int VW   = EW * DOTW;
    localparam int MICW = 64;
    localparam int IAW  = 9;
    localparam int CNTW = 16;
    localparam int CYCW = 32;
    localparam int MAXN = 32;

    logic clk = 1'b0;
    logic rst;

    logic            i_cmd_valid;
    logic            o_cmd_ready;
    logic [IAW:0]    i_num_inst;
    logic [CNTW-1:0] i_num_inputs;
    logic [CNTW-1:0] i_num_outputs;
    logic [31:0]     i_pc_offset;
    logic            i_inst_valid;
    logic            o_inst_ready;
    logic [MICW-1:0] i_inst_data;
    logic            o_inst_wr_en;
    logic [IAW-1:0]  o_inst_wr_addr;
    logic [MICW-1:0] o_inst_wr_data;
    logic            i_in_valid;
    logic            o_in_ready;
    logic [VW-1:0]   i_in_data;
    logic            o_ld_in_wr_en;
    logic [VW-1:0]   o_ld_in_wr_din;
    logic            i_ld_in_wr_rdy0;
    logic            i_ld_in_wr_rdy1;
    logic            o_start;
    logic [31:0]     o_pc_start_offset;
    logic            i_ld_out_rd_rdy0;
    logic            i_ld_out_rd_rdy1;
    logic [VW-1:0]   i_ld_out_rd_dout0;
    logic [VW-1:0]   i_ld_out_rd_dout1;
    logic            o_ld_out_rd_en;
    logic            o_out_valid;
    logic            i_out_ready;
    logic [VW-1:0]   o_out_data;
    logic            o_mismatch;
    logic [CYCW-1:0] o_cycles;
    logic            o_busy;
    logic            o_done;

    always #5 clk = ~clk;

    npu_host_seq dut (
        .clk               (clk),
        .rst               (rst),
        .i_cmd_valid       (i_cmd_valid),
        .o_cmd_ready       (o_cmd_ready),
        .i_num_inst        (i_num_inst),
        .i_num_inputs      (i_num_inputs),
        .i_num_outputs     (i_num_outputs),
        .i_pc_offset       (i_pc_offset),
        .i_inst_valid      (i_inst_valid),
        .o_inst_ready      (o_inst_ready),
        .i_inst_data       (i_inst_data),
        .o_inst_wr_en      (o_inst_wr_en),
        .o_inst_wr_addr    (o_inst_wr_addr),
        .o_inst_wr_data    (o_inst_wr_data),
        .i_in_valid        (i_in_valid),
        .o_in_ready        (o_in_ready),
        .i_in_data         (i_in_data),
        .o_ld_in_wr_en     (o_ld_in_wr_en),
        .o_ld_in_wr_din    (o_ld_in_wr_din),
        .i_ld_in_wr_rdy0   (i_ld_in_wr_rdy0),
        .i_ld_in_wr_rdy1   (i_ld_in_wr_rdy1),
        .o_start           (o_start),
        .o_pc_start_offset (o_pc_start_offset),
        .i_ld_out_rd_rdy0  (i_ld_out_rd_rdy0),
        .i_ld_out_rd_rdy1  (i_ld_out_rd_rdy1),
        .i_ld_out_rd_dout0 (i_ld_out_rd_dout0),
        .i_ld_out_rd_dout1 (i_ld_out_rd_dout1),
        .o_ld_out_rd_en    (o_ld_out_rd_en),
        .o_out_valid       (o_out_valid),
        .i_out_ready       (i_out_ready),
        .o_out_data        (o_out_data),
        .o_mismatch        (o_mismatch),
        .o_cycles          (o_cycles),
        .o_busy            (o_busy),
        .o_done            (o_done)
    );

    int vectors = 0;
    int errors  = 0;

    // Stimulus knobs (percent) and directed overrides
    int p_src   = 100;
    int p_ldin  = 100;
    int p_ldout = 100;
    int p_sink  = 100;
    int skew_left = 0;
    int hold_left = 0;

    // Current command
    int          n_inst;
    int          n_in;
    int          n_out;
    int          bad_idx;
    logic [31:0] pc_cmd;
    bit          cmd_pend;
    logic [MICW-1:0] inst_items [MAXN];
    logic [VW-1:0]   in_items   [MAXN];
    logic [VW-1:0]   out_items  [MAXN];

    // Reference model state
    int  inst_idx, in_idx, rd_idx;
    int  inst_wr, in_wr, rd_cnt, acc_cnt, starts;
    int  cyc, t_acc, t_start, t_last_rd, t_last_acc, t_done;
    bit  active, run_done, mm_model;
    bit  done_prev, acc_prev, prev_hold;
    int  pc_model;
    int  cyc_model;
    logic [VW-1:0] prev_data;
    logic [VW-1:0] exp_q [$];

    task automatic chk_i(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    task automatic chk_v(input string name, input logic [VW-1:0] act,
                         input logic [VW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic bit roll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic model_reset();
        inst_idx = 0; in_idx = 0; rd_idx = 0;
        inst_wr = 0; in_wr = 0; rd_cnt = 0; acc_cnt = 0; starts = 0;
        active = 0; run_done = 0; mm_model = 0;
        done_prev = 0; acc_prev = 0; prev_hold = 0;
        pc_model = 0; cyc_model = 0; cmd_pend = 0;
        n_inst = 0; n_in = 0; n_out = 0; bad_idx = -1;
        exp_q.delete();
    endtask

    task automatic drive();
        i_cmd_valid   = cmd_pend;
        i_num_inst    = (IAW+1)'(n_inst);
        i_num_inputs  = CNTW'(n_in);
        i_num_outputs = CNTW'(n_out);
        i_pc_offset   = pc_cmd;
        i_inst_valid  = (inst_idx < n_inst) && roll(p_src);
        i_inst_data   = inst_items[inst_idx % MAXN];
        i_in_valid    = (in_idx < n_in) && roll(p_src);
        i_in_data     = in_items[in_idx % MAXN];
        i_ld_in_wr_rdy0 = roll(p_ldin);
        i_ld_in_wr_rdy1 = roll(p_ldin);
        if (skew_left > 0 && active && inst_wr == n_inst && in_wr < n_in) begin
            i_ld_in_wr_rdy0 = 1'b1;
            i_ld_in_wr_rdy1 = 1'b0;
            skew_left--;
        end
        i_ld_out_rd_rdy0  = (rd_idx < n_out) && roll(p_ldout);
        i_ld_out_rd_rdy1  = (rd_idx < n_out) && roll(p_ldout);
        i_ld_out_rd_dout0 = out_items[rd_idx % MAXN];
        i_ld_out_rd_dout1 = (rd_idx == bad_idx) ? ~out_items[rd_idx % MAXN]
                                                : out_items[rd_idx % MAXN];
        i_out_ready = roll(p_sink);
        if (hold_left > 0 && rd_cnt >= 1) begin
            i_out_ready = 1'b0;
            hold_left--;
        end
    endtask

    // Compare DUT against the model, then advance the model by this cycle
    task automatic sample();
        int exp_cyc;
        int exp_t;
        cyc++;
        chk_i("busy_vs_ready", int'(o_busy), int'(!o_cmd_ready));
        if (done_prev) chk_i("ready_after_done", int'(o_cmd_ready), 1);
        if (acc_prev) begin
            chk_i("cycles_cleared", int'(o_cycles), 0);
            chk_i("addr_cleared", int'(o_inst_wr_addr), 0);
        end
        chk_i("in_ready_lockstep",
              int'(o_in_ready && !(i_ld_in_wr_rdy0 && i_ld_in_wr_rdy1)), 0);
        chk_i("in_wr_en", int'(o_ld_in_wr_en), int'(i_in_valid && o_in_ready));
        chk_i("inst_wr_en", int'(o_inst_wr_en), int'(i_inst_valid && o_inst_ready));
        chk_i("rd_en_gate", int'(o_ld_out_rd_en && !(i_ld_out_rd_rdy0
              && i_ld_out_rd_rdy1 && (!o_out_valid || i_out_ready))), 0);
        chk_i("mismatch", int'(o_mismatch), int'(mm_model));
        chk_i("pc_offset", int'(o_pc_start_offset), pc_model);
        if (prev_hold) begin
            chk_i("held_valid", int'(o_out_valid), 1);
            chk_v("held_data", o_out_data, prev_data);
        end
        if (!active) chk_i("idle_cycles", int'(o_cycles), cyc_model);

        if (o_inst_wr_en) begin
            chk_i("inst_order", int'(active && in_wr == 0 && starts == 0
                  && inst_wr < n_inst), 1);
            chk_i("inst_addr", int'(o_inst_wr_addr), inst_wr);
            chk_v("inst_data", VW'(o_inst_wr_data), VW'(inst_items[inst_wr % MAXN]));
            inst_wr++;
        end
        if (i_inst_valid && o_inst_ready) inst_idx++;

        if (o_ld_in_wr_en) begin
            chk_i("in_order", int'(active && inst_wr == n_inst && starts == 0
                  && in_wr < n_in), 1);
            chk_v("in_data", o_ld_in_wr_din, in_items[in_wr % MAXN]);
            in_wr++;
        end
        if (i_in_valid && o_in_ready) in_idx++;

        if (o_start) begin
            chk_i("start_order", int'(active && inst_wr == n_inst
                  && in_wr == n_in && starts == 0), 1);
            chk_i("start_pc", int'(o_pc_start_offset), int'(pc_cmd));
            starts++;
            t_start = cyc;
        end

        if (o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                chk_i("spurious_result", 1, 0);
            end else begin
                chk_v("result_data", o_out_data, exp_q.pop_front());
            end
            acc_cnt++;
            t_last_acc = cyc;
        end

        if (o_ld_out_rd_en) begin
            chk_i("rd_order", int'(active && starts == 1 && rd_cnt < n_out), 1);
            exp_q.push_back(out_items[rd_cnt % MAXN]);
            if (rd_cnt == bad_idx) mm_model = 1;
            rd_cnt++;
            rd_idx++;
            t_last_rd = cyc;
        end

        if (o_done) begin
            exp_cyc = (n_out > 0) ? t_last_rd - t_start + 1 : 2;
            exp_t   = (n_out > 0) ? t_last_acc + 1 : t_start + 2;
            chk_i("done_in_run", int'(active), 1);
            chk_i("done_time", cyc, exp_t);
            chk_i("done_reads", rd_cnt, n_out);
            chk_i("done_results", acc_cnt, n_out);
            chk_i("done_cycles", int'(o_cycles), exp_cyc);
            chk_i("done_mismatch", int'(o_mismatch),
                  int'(bad_idx >= 0 && bad_idx < n_out));
            cyc_model = exp_cyc;
            t_done = cyc;
            active = 0;
            run_done = 1;
        end

        acc_prev = 0;
        if (i_cmd_valid && o_cmd_ready) begin
            active = 1; run_done = 0; cmd_pend = 0;
            inst_idx = 0; in_idx = 0; rd_idx = 0;
            inst_wr = 0; in_wr = 0; rd_cnt = 0; acc_cnt = 0; starts = 0;
            pc_model = int'(pc_cmd);
            mm_model = 0;
            t_acc = cyc;
            acc_prev = 1;
            exp_q.delete();
        end

        done_prev = o_done;
        prev_hold = o_out_valid && !i_out_ready;
        prev_data = o_out_data;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic setup(input int ni, input int nin, input int nout,
                         input logic [31:0] pc, input int bad);
        n_inst = ni; n_in = nin; n_out = nout; pc_cmd = pc; bad_idx = bad;
        for (int k = 0; k < MAXN; k++) begin
            inst_items[k] = {$urandom, $urandom};
            in_items[k]   = rnd_vec();
            out_items[k]  = rnd_vec();
        end
        cmd_pend = 1;
        run_done = 0;
    endtask

    task automatic run_cmd(input int ni, input int nin, input int nout,
                           input logic [31:0] pc, input int bad);
        setup(ni, nin, nout, pc, bad);
        for (int k = 0; k < 4000 && !run_done; k++) cycle();
        if (!run_done) begin
            chk_i("run_timeout", 0, 1);
            do_reset();
        end else begin
            cycle();
        end
    endtask

    initial begin
        rst = 1'b0;
        pc_cmd = '0;
        for (int k = 0; k < MAXN; k++) begin
            inst_items[k] = '0;
            in_items[k]   = '0;
            out_items[k]  = '0;
        end
        cyc = 0;
        model_reset();
        drive();
        #12;
        chk_i("rst_cmd_ready", int'(o_cmd_ready), 1);
        chk_i("rst_busy", int'(o_busy), 0);
        chk_i("rst_out_valid", int'(o_out_valid), 0);
        chk_i("rst_mismatch", int'(o_mismatch), 0);
        chk_i("rst_cycles", int'(o_cycles), 0);
        chk_i("rst_done", int'(o_done), 0);
        chk_i("rst_start", int'(o_start), 0);
        chk_i("rst_pc", int'(o_pc_start_offset), 0);
        chk_i("rst_addr", int'(o_inst_wr_addr), 0);
        @(posedge clk);
        #2 rst = 1'b1;

        // Nominal run with hand-derived timing
        run_cmd(3, 2, 2, 32'h10, -1);
        chk_i("nom_start_time", t_start - t_acc, 6);
        chk_i("nom_done_time", t_done - t_acc, 10);
        chk_i("nom_cycles", int'(o_cycles), 3);
        chk_i("nom_mismatch", int'(o_mismatch), 0);

        // Input port skew
        skew_left = 5;
        run_cmd(2, 4, 1, 32'h24, -1);

        // Output backpressure
        hold_left = 4;
        run_cmd(1, 1, 4, 32'h30, -1);

        // Mismatch on output 1 of 3, sticky until next accept
        run_cmd(1, 1, 3, 32'h44, 1);
        chk_i("mm_sticky", int'(o_mismatch), 1);

        // All-zero counts
        run_cmd(0, 0, 0, 32'h58, -1);
        chk_i("zero_start_time", t_start - t_acc, 3);
        chk_i("zero_done_time", t_done - t_acc, 5);
        chk_i("zero_cycles", int'(o_cycles), 2);
        chk_i("zero_mismatch_cleared", int'(o_mismatch), 0);

        // Reset in the middle of DRAIN
        p_sink = 0;
        setup(1, 1, 6, 32'h6C, 0);
        for (int k = 0; k < 200 && rd_cnt < 1; k++) cycle();
        chk_i("mid_drain_reached", int'(rd_cnt >= 1), 1);
        cycle();
        cycle();
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_i("arst_busy", int'(o_busy), 0);
        chk_i("arst_out_valid", int'(o_out_valid), 0);
        chk_i("arst_mismatch", int'(o_mismatch), 0);
        chk_i("arst_cycles", int'(o_cycles), 0);
        chk_i("arst_rd_en", int'(o_ld_out_rd_en), 0);
        chk_i("arst_done", int'(o_done), 0);
        chk_i("arst_pc", int'(o_pc_start_offset), 0);
        model_reset();
        p_sink = 100;
        @(posedge clk);
        #2 rst = 1'b1;
        cycle();
        chk_i("post_rst_ready", int'(o_cmd_ready), 1);
        run_cmd(2, 2, 2, 32'h80, -1);

        // Randomized runs
        for (int r = 0; r < 30; r++) begin
            int ni, nin, nout, bad;
            p_src   = $urandom_range(40, 100);
            p_ldin  = $urandom_range(40, 100);
            p_ldout = $urandom_range(50, 100);
            p_sink  = $urandom_range(30, 100);
            ni   = ($urandom_range(4) == 0) ? 0 : $urandom_range(1, 12);
            nin  = ($urandom_range(4) == 0) ? 0 : $urandom_range(1, 12);
            nout = ($urandom_range(4) == 0) ? 0 : $urandom_range(1, 12);
            bad  = ($urandom_range(2) == 0) ? $urandom_range(0, 12) : -1;
            run_cmd(ni, nin, nout, $urandom, bad);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
